perf_counter_unit: RTL

- Synthesizable performance and statistics monitor sitting directly downstream of the pipelined cpu.
- Consumes the cpu's commit signals (hlt, register write, memory write) and its I-cache/D-cache request and hit strobes.
- Accumulates cycle, retired-instruction and cache request/hit counts; freezes on halt; flags a runaway-program watchdog timeout.
- Exposes all counts through a registered read port for on-chip or debug readout after the run.

---
 rtl/perf_counter_unit_if.sv | 51 +++++
 rtl/perf_counter_unit.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/perf_counter_unit_if.sv
// Bundle between the cpu commit/cache strobes, the read port and the monitor.
// The snap strobe exists only when PERF_SNAPSHOT_EN is defined.
interface perf_counter_unit_if #(
  parameter int CNT_W = 32
);
  logic             start;
  logic             clr;
  logic             hlt;
  logic             reg_write;
  logic             mem_write;
  logic             icache_req;
  logic             icache_hit;
  logic             dcache_req;
  logic             dcache_hit;
  logic             rd_en;
  logic [2:0]       rd_sel;
  logic [CNT_W-1:0] rd_data;
  logic             rd_valid;
  logic             busy;
  logic             done;
  logic             timeout;
`ifdef PERF_SNAPSHOT_EN
  logic             snap;
`endif

  modport master (
`ifdef PERF_SNAPSHOT_EN
    output snap,
`endif
    output start, clr, hlt,
    output reg_write, mem_write,
    output icache_req, icache_hit,
    output dcache_req, dcache_hit,
    output rd_en, rd_sel,
    input  rd_data, rd_valid,
    input  busy, done, timeout
  );

  modport slave (
`ifdef PERF_SNAPSHOT_EN
    input  snap,
`endif
    input  start, clr, hlt,
    input  reg_write, mem_write,
    input  icache_req, icache_hit,
    input  dcache_req, dcache_hit,
    input  rd_en, rd_sel,
    output rd_data, rd_valid,
    output busy, done, timeout
  );
endinterface

// File: rtl/perf_counter_unit.sv
// Cycle/retire/cache statistics monitor with watchdog and registered read port.
// Optional shadow snapshot registers: define PERF_SNAPSHOT_EN.
module perf_counter_unit #(
  parameter int CNT_W       = 32,
  parameter int CYCLE_LIMIT = 100000
) (
  input logic                clk,
  input logic                rst,
  perf_counter_unit_if.slave pcu
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_HALTED  = 2'd2,
    S_TIMEOUT = 2'd3
  } state_e;

  localparam int               NC      = 6;
  localparam logic [CNT_W-1:0] MAX     = '1;
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam bit               WD_EN   = (CYCLE_LIMIT != 0);
  localparam logic [31:0]      WD_LAST = 32'(CYCLE_LIMIT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q [NC];
  logic [CNT_W-1:0] cnt_d [NC];
  logic [NC-1:0]    ovf_q, ovf_d;
  logic [NC-1:0]    inc;
  logic             err_q, err_d;
  logic             to_q, to_d;
  logic             wd_hit;
  logic             hit_err;
  logic [CNT_W-1:0] rd_data_q;
  logic             rd_valid_q;
  logic [CNT_W-1:0] rd_mux;
  logic [CNT_W-1:0] status;
  logic [CNT_W-1:0] src [NC];

  assign inc = {
    pcu.dcache_hit & pcu.dcache_req,
    pcu.dcache_req,
    pcu.icache_hit & pcu.icache_req,
    pcu.icache_req,
    pcu.hlt | pcu.reg_write | pcu.mem_write,
    1'b1
  };

  assign hit_err = (pcu.icache_hit & ~pcu.icache_req)
                 | (pcu.dcache_hit & ~pcu.dcache_req);

  // Compare at 32 bits so a limit wider than the counter never fires.
  assign wd_hit = WD_EN && (32'(cnt_q[0]) == WD_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    to_d    = to_q;
    unique case (state_q)
      S_IDLE: begin
        if (pcu.start) state_d = S_RUN;
      end
      S_RUN: begin
        for (int i = 0; i < NC; i++) begin
          if (inc[i]) begin
            if (cnt_q[i] == MAX) ovf_d[i] = 1'b1;
            else cnt_d[i] = cnt_q[i] + ONE;
          end
        end
        if (hit_err) err_d = 1'b1;
        if (pcu.hlt) begin
          state_d = S_HALTED;
        end else if (wd_hit) begin
          state_d = S_TIMEOUT;
          to_d    = 1'b1;
        end
      end
      default: ;
    endcase
    if (pcu.clr) begin
      state_d = S_IDLE;
      for (int i = 0; i < NC; i++) cnt_d[i] = '0;
      ovf_d = '0;
      err_d = 1'b0;
      to_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      for (int i = 0; i < NC; i++) cnt_q[i] <= '0;
      ovf_q   <= '0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      to_q    <= to_d;
    end
  end

`ifdef PERF_SNAPSHOT_EN
  logic [CNT_W-1:0] shd_q [NC];
  logic [CNT_W-1:0] shd_d [NC];
  logic             fin_entry;

  assign fin_entry = (state_q == S_RUN)
                   && (state_d inside {S_HALTED, S_TIMEOUT});

  always_comb begin
    shd_d = shd_q;
    if (pcu.snap) shd_d = cnt_q;
    // Final totals win over a same-edge manual snap.
    if (fin_entry) shd_d = cnt_d;
    if (pcu.clr) begin
      for (int i = 0; i < NC; i++) shd_d[i] = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NC; i++) shd_q[i] <= '0;
    end else begin
      shd_q <= shd_d;
    end
  end

  assign src = shd_q;
`else
  assign src = cnt_q;
`endif

  assign status = CNT_W'({22'd0, ovf_q, err_q, to_q, state_q});

  always_comb begin
    rd_mux = '0;
    case (pcu.rd_sel)
      3'd0:    rd_mux = src[0];
      3'd1:    rd_mux = src[1];
      3'd2:    rd_mux = src[2];
      3'd3:    rd_mux = src[3];
      3'd4:    rd_mux = src[4];
      3'd5:    rd_mux = src[5];
      3'd6:    rd_mux = status;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= pcu.rd_en;
      if (pcu.rd_en) rd_data_q <= rd_mux;
    end
  end

  assign pcu.rd_data  = rd_data_q;
  assign pcu.rd_valid = rd_valid_q;
  assign pcu.busy     = (state_q == S_RUN);
  assign pcu.done     = (state_q == S_HALTED);
  assign pcu.timeout  = (state_q == S_TIMEOUT);

endmodule
